// File: rtl/multi_cycle_mul_if.sv
// Request/response bundle between EX and the iterative multiplier.
// Same valid/ready hold handshake as the divider: EX holds valid until ready.
interface mul_if;
    logic         valid;
    logic [1:0]   mul_signed;
    logic         mul_32;
    logic [63:0]  rs1_data;
    logic [63:0]  rs2_data;
    logic         ready;
    logic [127:0] mul_result;

    modport master (
        output valid, mul_signed, mul_32, rs1_data, rs2_data,
        input  ready, mul_result
    );
    modport slave (
        input  valid, mul_signed, mul_32, rs1_data, rs2_data,
        output ready, mul_result
    );
endinterface

// File: rtl/multi_cycle_mul.sv
// Iterative radix-4 Booth multiplier, 65x65 -> 130 bit, one digit per cycle.
// Optional MUL_EARLY_OUT_EN: W operations finish after 17 digits instead of 33.
module multi_cycle_mul (
    input  logic  clk,
    input  logic  rst,
    mul_if.slave  bus
);
    localparam logic [5:0] LAST_FULL = 6'd34;
`ifdef MUL_EARLY_OUT_EN
    localparam logic [5:0] LAST_W    = 6'd18;
`endif

    typedef enum logic [1:0] {PH_LOAD, PH_STEP, PH_DONE} phase_e;

    logic [5:0]   counter_q, counter_d;
    logic [129:0] acc_q, acc_d;
    logic [129:0] mcand_q, mcand_d;
    logic [66:0]  mplier_q, mplier_d;
`ifdef MUL_EARLY_OUT_EN
    logic         w_q, w_d;
`endif

    logic [5:0]   last_cnt;
    phase_e       phase;
    logic [64:0]  ext_a, ext_b;
    logic         s1, s2;
    logic         bneg, bone, btwo;
    logic [129:0] mag, pp;

    // Operand extension: W mode takes the low word and extends per signedness.
    always_comb begin
        s1 = bus.mul_signed[1];
        s2 = bus.mul_signed[0];
        if (bus.mul_32) begin
            ext_a = {{33{s1 & bus.rs1_data[31]}}, bus.rs1_data[31:0]};
            ext_b = {{33{s2 & bus.rs2_data[31]}}, bus.rs2_data[31:0]};
        end else begin
            ext_a = {s1 & bus.rs1_data[63], bus.rs1_data};
            ext_b = {s2 & bus.rs2_data[63], bus.rs2_data};
        end
    end

    always_comb begin
`ifdef MUL_EARLY_OUT_EN
        last_cnt = w_q ? LAST_W : LAST_FULL;
`else
        last_cnt = LAST_FULL;
`endif
        if (counter_q == 6'd0)          phase = PH_LOAD;
        else if (counter_q == last_cnt) phase = PH_DONE;
        else                            phase = PH_STEP;
    end

    // Booth digit from {b[2k+1], b[2k], b[2k-1]}; negation is invert + carry-in.
    always_comb begin
        bneg = 1'b0;
        bone = 1'b0;
        btwo = 1'b0;
        case (mplier_q[2:0])
            3'b001, 3'b010: bone = 1'b1;
            3'b011:         btwo = 1'b1;
            3'b100:         begin btwo = 1'b1; bneg = 1'b1; end
            3'b101, 3'b110: begin bone = 1'b1; bneg = 1'b1; end
            default:        ;
        endcase
        if (btwo)      mag = {mcand_q[128:0], 1'b0};
        else if (bone) mag = mcand_q;
        else           mag = '0;
        pp = bneg ? ~mag : mag;
    end

    always_comb begin
        counter_d = counter_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`ifdef MUL_EARLY_OUT_EN
        w_d       = w_q;
`endif
        if (!bus.valid) begin
            counter_d = 6'd0;
            acc_d     = '0;
        end else begin
            case (phase)
                PH_LOAD: begin
                    counter_d = 6'd1;
                    acc_d     = '0;
                    mcand_d   = {{65{ext_a[64]}}, ext_a};
                    mplier_d  = {ext_b[64], ext_b, 1'b0};
`ifdef MUL_EARLY_OUT_EN
                    w_d       = bus.mul_32;
`endif
                end
                PH_STEP: begin
                    counter_d = counter_q + 6'd1;
                    acc_d     = acc_q + pp + {129'd0, bneg};
                    mcand_d   = {mcand_q[127:0], 2'b00};
                    mplier_d  = {{2{mplier_q[66]}}, mplier_q[66:2]};
                end
                default: counter_d = 6'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q <= 6'd0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
`ifdef MUL_EARLY_OUT_EN
            w_q       <= 1'b0;
`endif
        end else begin
            counter_q <= counter_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
`ifdef MUL_EARLY_OUT_EN
            w_q       <= w_d;
`endif
        end
    end

    assign bus.ready      = ~rst & bus.valid & (phase == PH_DONE);
    assign bus.mul_result = rst ? 128'd0 : acc_q[127:0];
endmodule

// File: tb/tb_multi_cycle_mul.sv
// Self-checking bench for multi_cycle_mul: vector table, random model checks,
// abort/reset/back-to-back sequences with a result scoreboard.
module tb_multi_cycle_mul;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_if bus ();
    multi_cycle_mul dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string        nm;
        logic [1:0]   sgn;
        logic         w;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    int tests = 0;
    int fails = 0;
    logic [127:0] sb_q[$];
    vec_t vt[7];

`ifdef MUL_EARLY_OUT_EN
    localparam int LAT_W = 18;
`else
    localparam int LAT_W = 34;
`endif

    function automatic int exp_lat(input logic w);
        return w ? LAT_W : 34;
    endfunction

    function automatic logic [127:0] model(input logic [1:0] s, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] ea, eb, p;
        if (w) begin
            ea = $signed({{98{s[1] & a[31]}}, a[31:0]});
            eb = $signed({{98{s[0] & b[31]}}, b[31:0]});
        end else begin
            ea = $signed({{66{s[1] & a[63]}}, a});
            eb = $signed({{66{s[0] & b[63]}}, b});
        end
        p = ea * eb;
        return p[127:0];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic w, input logic [63:0] a, input logic [63:0] b);
        bus.valid      = 1'b1;
        bus.mul_signed = s;
        bus.mul_32     = w;
        bus.rs1_data   = a;
        bus.rs2_data   = b;
    endtask

    // Counts rising edges from the current negedge until ready is seen.
    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.ready !== 1'b1 && lat < 100);
    endtask

    task automatic pop_check(input string nm);
        logic [127:0] e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: ready with empty scoreboard", nm);
        end else begin
            e = sb_q.pop_front();
            chk(nm, bus.mul_result, e);
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] s, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [127:0] e);
        int lat;
        @(negedge clk);
        drive(s, w, a, b);
        sb_q.push_back(e);
        wait_ready(lat);
        chk({nm, "_lat"}, 128'(lat), 128'(exp_lat(w)));
        pop_check(nm);
        bus.valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] ra, rb;
        logic [1:0]  rs;
        logic        rw;

        vt[0] = '{"mulhu_max", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vt[1] = '{"mul_neg3x7", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                  {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB}};
        vt[2] = '{"mul_minsq", 2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vt[3] = '{"mulhsu", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
        vt[4] = '{"mulw", 2'b11, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
                  128'h0000_0000_0000_0000_0000_0000_FFFF_FFFE};
        vt[5] = '{"mulw_neg", 2'b11, 1'b1, 64'h0BAD_F00D_FFFF_FFFF, 64'hCAFE_0000_0000_0003,
                  {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD}};
        vt[6] = '{"mulw_u", 2'b00, 1'b1, 64'h5555_5555_FFFF_FFFF, 64'hAAAA_AAAA_FFFF_FFFF,
                  128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001};

        rst            = 1'b1;
        bus.valid      = 1'b0;
        bus.mul_signed = 2'b00;
        bus.mul_32     = 1'b0;
        bus.rs1_data   = '0;
        bus.rs2_data   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(bus.ready), 128'd0);
        chk("rst_result", bus.mul_result, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_result", bus.mul_result, 128'd0);

        foreach (vt[i]) run_op(vt[i].nm, vt[i].sgn, vt[i].w, vt[i].a, vt[i].b, vt[i].exp);

        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            run_op("rand", rs, rw, ra, rb, model(rs, rw, ra, rb));
        end

        // Abort at counter 10, then reissue.
        @(negedge clk);
        drive(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (10) @(negedge clk);
        chk("abort_noready", 128'(bus.ready), 128'd0);
        bus.valid = 1'b0;
        @(negedge clk);
        chk("abort_acc", bus.mul_result, 128'd0);
        run_op("after_abort", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
               {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});

        // Reset at counter 20.
        @(negedge clk);
        drive(2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 128'(bus.ready), 128'd0);
        chk("midrst_result", bus.mul_result, 128'd0);
        @(negedge clk);
        bus.valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("postrst_ready", 128'(bus.ready), 128'd0);
        chk("postrst_result", bus.mul_result, 128'd0);
        run_op("after_rst", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);

        // Back-to-back with valid held.
        @(negedge clk);
        drive(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        sb_q.push_back(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        wait_ready(lat);
        chk("b2b_lat1", 128'(lat), 128'd34);
        pop_check("b2b_res1");
        drive(2'b11, 1'b0, 64'd12345, 64'hFFFF_FFFF_FFFF_FF00);
        sb_q.push_back(model(2'b11, 1'b0, 64'd12345, 64'hFFFF_FFFF_FFFF_FF00));
        wait_ready(lat);
        chk("b2b_lat2", 128'(lat), 128'd35);
        pop_check("b2b_res2");
        @(negedge clk);
        chk("b2b_pulse", 128'(bus.ready), 128'd0);
        bus.valid = 1'b0;
        chk("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multi_cycle_mul.md
# multi_cycle_mul

Iterative radix-4 Booth multiplier for the EX stage, the multiply counterpart of the multi-cycle divider on the M-extension path. It accepts two 64-bit register operands, with per-operand signedness and a 32-bit (W) mode, and produces the exact 128-bit product after a fixed number of cycles. It uses the same valid/ready hold handshake as the divider, so EX stalls on both units identically.

## Interface
Parameters: none; widths come from `defines.v`, where `REG_BUS` is 63:0.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- valid  in  1  operation request; held high by EX until `ready`.
- mul_signed  in  2  signedness: [1] marks rs1 signed, [0] marks rs2 signed.
  - MUL/MULH = 2'b11; MULHSU = 2'b10; MULHU = 2'b00.
- mul_32  in  1  W mode: operands taken from bits [31:0] and extended per `mul_signed`.
- rs1_data  in  64  multiplicand.
- rs2_data  in  64  multiplier.
- ready  out  1  result valid this cycle; combinational from the counter, gated by `~rst & valid`.
- mul_result  out  128  full product of the extended operands; EX selects the low or high half and sign-extends [31:0] for MULW.

## Operation
- Operand extension:
  - 64-bit mode: A = {s1&rs1[63], rs1}, B = {s2&rs2[63], rs2}, both 65 bits.
  - mul_32: A = {33{s1&rs1[31]}, rs1[31:0]}; B likewise from rs2 and s2.
- A is sign-extended to a 130-bit shifted multiplicand. B is sign-extended to 66 bits and scanned as 33 overlapping radix-4 Booth digits in {-2,-1,0,+1,+2}. Negation uses invert plus carry-in.
- State:
  - counter (6 bit)
  - acc (130 bit)
  - mcand (130 bit, shifted left 2 per step)
  - mplier (67 bit: B plus the appended 0, shifted right 2 per step)
- Counter values:
  - 0 = IDLE/LOAD: latch the extended operands and clear acc.
  - 1..33 = STEP: add digit k-1 into acc.
  - 34 = DONE.
- mul_result = acc[127:0]. The product is exact for all sign combinations, including 0x8000_0000_0000_0000 squared.
- valid low at any edge aborts: counter and acc return to 0 and partial results are discarded.
- Operand changes while counter != 0 are ignored, because the operands were latched at LOAD.

## Timing
- Reset: counter = 0, acc = 0, mcand = 0, mplier = 0. During and after reset, ready = 0 and mul_result = 0.
- rst asserted mid-operation: state is cleared at that edge; there is no ready pulse for the aborted operation.
- Latency: valid first high in cycle T (counter 0), ready = 1 in cycle T+34, so the operation occupies 35 cycles including the ready cycle.
- The ready cycle lasts exactly one cycle. At that edge counter returns to 0 and acc is held until the next LOAD.
- Back-to-back: if valid stays high after ready, the next cycle is LOAD of the new operands and the next ready comes 34 cycles later.
- No operand-dependent early termination exists, except the one described under Configuration.

## Configuration
- `MUL_EARLY_OUT_EN` defined: when `mul_32` was latched at LOAD, only 17 digits are processed.
  - Extended W operands fit in 34 bits.
  - ready asserts at counter == 18 (cycle T+18), and acc holds the exact product.
- Undefined: W operations take the full 34-step sequence, with ready at T+34. Results are identical in both builds; only latency differs.

## Test plan
- MULHU: rs1 = rs2 = 0xFFFF_FFFF_FFFF_FFFF, sign 2'b00 -> ready at T+34, mul_result = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Signed MUL: rs1 = -3, rs2 = 7, sign 2'b11 -> mul_result = 0xFFFF..FFEB (-21, 128 bit). Also rs1 = rs2 = 0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000_0000_0000_0000_0000.
- MULHSU: rs1 = -1, rs2 = 0xFFFF_FFFF_FFFF_FFFF, sign 2'b10 -> mul_result = 0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001.
- MULW: mul_32 = 1, sign 2'b11, rs1 = 0x7FFF_FFFF, rs2 = 2, upper operand bits randomized -> mul_result = 0x0..0_FFFF_FFFE. ready at T+18 with `MUL_EARLY_OUT_EN` defined, T+34 without.
- Abort and reset: drop valid at counter 10, then reissue -> full 35-cycle latency and correct result. In a separate run, assert rst at counter 20 -> ready stays 0, outputs read 0, and the next operation is correct.
- Back-to-back: two operations with valid held continuously -> two single-cycle ready pulses 35 cycles apart, and the second result is unaffected by the first.
